// File: rtl/selfcheck_pkg.sv
// Shared types and helpers for the processor self-check monitor.
package selfcheck_pkg;

    // Sequencer states: CPU held, CPU running, CPU frozen, then the
    // two-cycle read/compare walk over the expected-value table.
    typedef enum logic [2:0] {
        IDLE,
        RUN,
        FREEZE,
        READ,
        CMP,
        DONE
    } state_t;

    // Index width for a table of the given depth (at least one bit).
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/selfcheck_expect_table.sv
// Expected-value table: NUM_CHECKS entries of {valid, register, value}.
// One write port, asynchronous read at rd_idx. Only the valid bits are
// reset; register/value storage keeps whatever was last written.
module selfcheck_expect_table
    import selfcheck_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 5,
    parameter int NUM_CHECKS = 16,
    parameter int IDX_W      = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [REG_AW-1:0] wr_reg,
    input  logic [DATA_W-1:0] wr_val,
    input  logic              clr,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [REG_AW-1:0] rd_reg,
    output logic [DATA_W-1:0] rd_val
);

    logic [NUM_CHECKS-1:0] valid_q;
    logic [REG_AW-1:0]     reg_q [NUM_CHECKS];
    logic [DATA_W-1:0]     val_q [NUM_CHECKS];
    logic [31:0]           wr_idx_ext;
    logic                  wr_ok;

    // Out-of-range indices are dropped; a clear in the same cycle wins.
    assign wr_idx_ext = 32'(wr_idx);
    assign wr_ok      = wr_en && !clr && (wr_idx_ext < 32'(NUM_CHECKS));

    // Valid bits: cleared by reset or clear, set by a write.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else if (clr) begin
            valid_q <= '0;
        end else if (wr_ok) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Entry payload storage, no reset.
    always_ff @(posedge clock) begin
        if (wr_ok) begin
            reg_q[wr_idx] <= wr_reg;
            val_q[wr_idx] <= wr_val;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_reg   = reg_q[rd_idx];
    assign rd_val   = val_q[rd_idx];

endmodule

// File: rtl/processor_selfcheck_monitor.sv
// On-board register self-test sequencer. Holds the CPU in reset until
// start, lets it run CYCLE_LIMIT cycles, freezes it, then walks the
// expected-value table through the regfile debug port and reports
// pass/fail, error count and the first failing table index.
// Build option SELFCHECK_SNAPSHOT_EN: also latch the register number and
// the value read back at the first mismatch (fail_reg / fail_read);
// without it those ports are tied to zero.
module processor_selfcheck_monitor
    import selfcheck_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int REG_AW      = 5,
    parameter int NUM_CHECKS  = 16,
    parameter int CYCLE_LIMIT = 400,
    parameter int CNT_W       = 16
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               exp_wr_en,
    input  logic [idx_width(NUM_CHECKS)-1:0]   exp_wr_idx,
    input  logic [REG_AW-1:0]                  exp_wr_reg,
    input  logic [DATA_W-1:0]                  exp_wr_val,
    input  logic                               exp_clr,
    output logic                               cpu_run,
    output logic                               cpu_freeze,
    output logic [REG_AW-1:0]                  dbg_rd_reg,
    input  logic [DATA_W-1:0]                  dbg_rd_data,
    output logic                               busy,
    output logic                               done,
    output logic                               pass,
    output logic [CNT_W-1:0]                   error_count,
    output logic [idx_width(NUM_CHECKS)-1:0]   fail_idx,
    output logic [REG_AW-1:0]                  fail_reg,
    output logic [DATA_W-1:0]                  fail_read
);

    localparam int IDX_W    = idx_width(NUM_CHECKS);
    // The run counter must reach CYCLE_LIMIT even when CNT_W is narrow.
    localparam int LIM_W    = (CYCLE_LIMIT > 0) ? $clog2(CYCLE_LIMIT + 1) : 1;
    localparam int CYC_W    = (CNT_W > LIM_W) ? CNT_W : LIM_W;
    localparam int RUN_LAST = (CYCLE_LIMIT > 0) ? CYCLE_LIMIT - 1 : 0;

    state_t            state, state_nxt;
    logic [CYC_W-1:0]  cyc_cnt;
    logic              rerun_q;
    logic [IDX_W-1:0]  idx;
    logic              tbl_valid;
    logic [REG_AW-1:0] tbl_reg;
    logic [DATA_W-1:0] tbl_val;
    logic              idle_or_done;
    logic              start_ok;
    logic              run_last;
    logic              idx_last;
    logic              mismatch;

    assign idle_or_done = (state == IDLE) || (state == DONE);
    assign start_ok     = start && idle_or_done;
    assign run_last     = (cyc_cnt == CYC_W'(RUN_LAST));
    assign idx_last     = (idx == IDX_W'(NUM_CHECKS - 1));
    assign mismatch     = (state == CMP) && tbl_valid && (dbg_rd_data != tbl_val);

    selfcheck_expect_table #(
        .DATA_W     (DATA_W),
        .REG_AW     (REG_AW),
        .NUM_CHECKS (NUM_CHECKS),
        .IDX_W      (IDX_W)
    ) u_table (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (exp_wr_en && idle_or_done),
        .wr_idx   (exp_wr_idx),
        .wr_reg   (exp_wr_reg),
        .wr_val   (exp_wr_val),
        .clr      (exp_clr && idle_or_done),
        .rd_idx   (idx),
        .rd_valid (tbl_valid),
        .rd_reg   (tbl_reg),
        .rd_val   (tbl_val)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and decoded outputs.
    always_comb begin
        state_nxt  = state;
        cpu_run    = 1'b0;
        cpu_freeze = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        dbg_rd_reg = '0;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                // First RUN cycle after a restart from DONE keeps the CPU in reset.
                cpu_run = !rerun_q;
                busy    = 1'b1;
                if (!rerun_q && run_last) state_nxt = FREEZE;
            end
            FREEZE: begin
                cpu_run    = 1'b1;
                cpu_freeze = 1'b1;
                busy       = 1'b1;
                state_nxt  = READ;
            end
            READ: begin
                cpu_run    = 1'b1;
                cpu_freeze = 1'b1;
                busy       = 1'b1;
                dbg_rd_reg = tbl_reg;
                state_nxt  = CMP;
            end
            CMP: begin
                cpu_run    = 1'b1;
                cpu_freeze = 1'b1;
                busy       = 1'b1;
                state_nxt  = idx_last ? DONE : READ;
            end
            DONE: begin
                cpu_run    = 1'b1;
                cpu_freeze = 1'b1;
                done       = 1'b1;
                if (start) state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Run-cycle counter and the one-cycle CPU re-reset flag on restart.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cyc_cnt <= '0;
            rerun_q <= 1'b0;
        end else begin
            rerun_q <= (state == DONE) && start;
            if (start_ok) begin
                cyc_cnt <= '0;
            end else if ((state == RUN) && !rerun_q) begin
                cyc_cnt <= cyc_cnt + CYC_W'(1);
            end
        end
    end

    // Table index, saturating error counter and first-fail index latch.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx         <= '0;
            error_count <= '0;
            fail_idx    <= '0;
        end else if (start_ok || (state == FREEZE)) begin
            idx         <= '0;
            error_count <= '0;
            fail_idx    <= '0;
        end else if (state == CMP) begin
            if (mismatch) begin
                if (error_count != '1) error_count <= error_count + CNT_W'(1);
                if (error_count == '0) fail_idx <= idx;
            end
            if (!idx_last) idx <= idx + IDX_W'(1);
        end
    end

    assign pass = done && (error_count == '0);

`ifdef SELFCHECK_SNAPSHOT_EN
    logic [REG_AW-1:0] snap_reg_q;
    logic [DATA_W-1:0] snap_read_q;

    // Register number and read-back value captured with the first mismatch.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            snap_reg_q  <= '0;
            snap_read_q <= '0;
        end else if (start_ok || (state == FREEZE)) begin
            snap_reg_q  <= '0;
            snap_read_q <= '0;
        end else if (mismatch && (error_count == '0)) begin
            snap_reg_q  <= tbl_reg;
            snap_read_q <= dbg_rd_data;
        end
    end

    assign fail_reg  = snap_reg_q;
    assign fail_read = snap_read_q;
`else
    assign fail_reg  = '0;
    assign fail_read = '0;
`endif

endmodule
